load_sequencer: RTL

Program-driven controller for the lab1 FSM datapath on the 50 MHz board clock. It stores a short script of (data, count) steps and replays them. For each step it issues a one-cycle load_en with the step's in/cnt values, then dwells for a prescaled number of ticks before the next step. Its outputs connect directly to lab1's load_en/in/cnt inputs, which replaces manual switch loading on the board top.

---
 rtl/load_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/load_sequencer.sv
// Script-driven loader for the lab1 datapath: replays stored (data, count) steps,
// one load_en strobe per step followed by a prescaled dwell.
module load_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int DEPTH    = 4,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PW      = $clog2(TICK_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic [1:0]    wr_cnt,
    input  logic [AW-1:0] len,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    output logic          load_en,
    output logic [3:0]    in_o,
    output logic [1:0]    cnt_o,
    output logic [AW-1:0] step,
    output logic          busy,
    output logic          done,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [3:0]    data_mem [DEPTH];
    logic [1:0]    cnt_mem  [DEPTH];
    logic [PW-1:0] presc, presc_nxt;
    logic [1:0]    dwell, dwell_nxt;
    logic [AW-1:0] step_nxt, last;
    logic [3:0]    in_nxt;
    logic [1:0]    cnt_nxt;
    logic          load_en_nxt, busy_nxt, done_nxt, tick;

    assign fsm_state = state;
    assign last      = (len > LAST_IDX) ? LAST_IDX : len;
    assign tick      = (presc == TICK_LAST);

    // Script RAM: writable only while the sequencer is idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                cnt_mem[i]  <= '0;
            end
        end else if (wr_en && state == IDLE && int'(wr_addr) < DEPTH) begin
            data_mem[wr_addr] <= wr_data;
            cnt_mem[wr_addr]  <= wr_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            presc   <= '0;
            dwell   <= '0;
            step    <= '0;
            load_en <= 1'b0;
            in_o    <= '0;
            cnt_o   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            dwell   <= dwell_nxt;
            step    <= step_nxt;
            load_en <= load_en_nxt;
            in_o    <= in_nxt;
            cnt_o   <= cnt_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        dwell_nxt   = dwell;
        step_nxt    = step;
        load_en_nxt = 1'b0;
        in_nxt      = in_o;
        cnt_nxt     = cnt_o;
        busy_nxt    = busy;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start && !stop) begin
                    state_nxt = LOAD;
                    step_nxt  = '0;
                end
            end
            LOAD: begin
                load_en_nxt = 1'b1;
                busy_nxt    = 1'b1;
                in_nxt      = data_mem[step];
                cnt_nxt     = cnt_mem[step];
                presc_nxt   = '0;
                dwell_nxt   = cnt_mem[step];
                state_nxt   = HOLD;
            end
            HOLD: begin
                busy_nxt = 1'b1;
                if (tick) begin
                    presc_nxt = '0;
                    if (dwell != 2'd0) begin
                        dwell_nxt = dwell - 2'd1;
                    end else if (step < last) begin
                        step_nxt  = step + AW'(1);
                        state_nxt = LOAD;
                    end else if (loop) begin
                        step_nxt  = '0;
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Abort wins over any tick or pending load; data outputs keep their values
        if (stop && state != IDLE) begin
            state_nxt   = IDLE;
            presc_nxt   = '0;
            dwell_nxt   = dwell;
            step_nxt    = step;
            load_en_nxt = 1'b0;
            in_nxt      = in_o;
            cnt_nxt     = cnt_o;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b0;
        end
    end

endmodule
